uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART peripheral. Generates the 16x-baud tick that paces the RX engine and accepts every byte the engine offers. Buffers accepted bytes in a small FIFO for the MMIO register block, and reports overrun and an idle-line receive timeout. It sits between the RX engine's valid/ready byte output and the MMIO read path.

---
 rtl/uart_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud tick, RX FIFO, overrun, idle timeout (option: UART_RX_TIMEOUT_EN)
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_en,
    input  logic [15:0]                   cfg_divisor,
    input  logic                          cfg_flush,
    input  logic                          clr_overrun,
    output logic                          baud_x16_tick,
    input  logic                          eng_valid,
    output logic                          eng_ready,
    input  logic [7:0]                    eng_data,
    input  logic                          eng_busy,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          timeout_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic push_req, pop, full, push_ok, drop;

    assign eng_ready     = 1'b1;
    assign baud_x16_tick = tick_q;
    assign rd_valid      = (level_q != '0);
    assign rd_data       = mem_q[rd_ptr_q];
    assign level         = level_q;
    assign overrun       = overrun_q;

    assign push_req = eng_valid && cfg_en;
    assign pop      = rd_valid && rd_ready;
    assign full     = (level_q == LW'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop && !cfg_flush;

    // Tick divider: registered pulse so the first tick lands divisor+1 cycles after enable.
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        if (!cfg_en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q >= cfg_divisor) begin
            tick_d    = 1'b1;
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    // FIFO pointers, occupancy and sticky overrun; flush wins over push and pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        mem_d     = mem_q;
        if (cfg_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = eng_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                level_d = level_q + 1'b1;
            end else if (!push_ok && pop) begin
                level_d = level_q - 1'b1;
            end
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CHARS * 160);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CHARS * 160 - 1);

    typedef enum logic [1:0] {T_IDLE, T_COUNT, T_FIRED} tstate_e;

    tstate_e       state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign timeout_irq = (state_q == T_FIRED);

    // Idle-line timeout: counts character time with data waiting and the line quiet.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        if (cfg_flush || !cfg_en) begin
            state_d = T_IDLE;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                T_IDLE: begin
                    tcnt_d = '0;
                    if (level_q != '0) begin
                        state_d = T_COUNT;
                    end
                end
                T_COUNT: begin
                    if (level_d == '0) begin
                        state_d = T_IDLE;
                        tcnt_d  = '0;
                    end else if (push_ok || pop) begin
                        tcnt_d = '0;
                    end else if (tick_q && !eng_busy) begin
                        if (tcnt_q == TLIM) begin
                            state_d = T_FIRED;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                T_FIRED: begin
                    if (level_d == '0) begin
                        state_d = T_IDLE;
                        tcnt_d  = '0;
                    end else if (pop && level_q > LW'(1)) begin
                        state_d = T_COUNT;
                        tcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = T_IDLE;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Timeout state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end
`else
    logic unused_busy;
    assign unused_busy = eng_busy;
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [15:0] cfg_divisor;
    logic        cfg_flush;
    logic        clr_overrun;
    logic        baud_x16_tick;
    logic        eng_valid;
    logic        eng_ready;
    logic [7:0]  eng_data;
    logic        eng_busy;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic [3:0]  level;
    logic        overrun;
    logic        timeout_irq;

    int tests = 0;
    int fails = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CHARS(1)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_divisor(cfg_divisor),
        .cfg_flush(cfg_flush), .clr_overrun(clr_overrun), .baud_x16_tick(baud_x16_tick),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_data(eng_data),
        .eng_busy(eng_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .level(level), .overrun(overrun), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        eng_valid = 1'b1;
        eng_data  = b;
        step();
        eng_valid = 1'b0;
    endtask

    task automatic pop1();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_en = 1'b0; cfg_divisor = 16'd3; cfg_flush = 1'b0;
        clr_overrun = 1'b0; eng_valid = 1'b0; eng_data = 8'h00; eng_busy = 1'b0;
        rd_ready = 1'b0;
        repeat (3) step();
        check("rst_tick", baud_x16_tick, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_irq, 0);
        check("rst_eng_ready", eng_ready, 1);
        rst = 1'b0;
        step();

        // tick rate with divisor 3
        cfg_en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            check("tick_rate", baud_x16_tick, 32'(i % 4 == 0));
        end
        cfg_en = 1'b0;
        step();
        check("tick_stop", baud_x16_tick, 0);
        step();
        check("tick_stop2", baud_x16_tick, 0);

        // bytes offered while disabled are discarded silently
        push(8'hEE);
        check("dis_level", level, 0);
        check("dis_rd_valid", rd_valid, 0);
        check("dis_overrun", overrun, 0);

        cfg_divisor = 16'd0;
        cfg_en = 1'b1;
        step();
        check("div0_tick", baud_x16_tick, 1);

        // ordering
        eng_valid = 1'b1;
        eng_data = 8'h55; step(); check("ord_lvl1", level, 1);
        check("ord_head", rd_data, 8'h55);
        eng_data = 8'hA3; step(); check("ord_lvl2", level, 2);
        eng_data = 8'h0F; step(); check("ord_lvl3", level, 3);
        eng_valid = 1'b0;
        check("ord_pop0", rd_data, 8'h55); pop1();
        check("ord_pop1", rd_data, 8'hA3); check("ord_plvl2", level, 2); pop1();
        check("ord_pop2", rd_data, 8'h0F); check("ord_plvl1", level, 1); pop1();
        check("ord_empty", rd_valid, 0);
        check("ord_lvl0", level, 0);

        // overrun
        eng_valid = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            eng_data = 8'(i);
            step();
            if (i == 7) begin
                check("ovr_full_lvl", level, 8);
                check("ovr_not_yet", overrun, 0);
            end
        end
        eng_valid = 1'b0;
        check("ovr_lvl", level, 8);
        check("ovr_set", overrun, 1);
        check("ovr_head", rd_data, 8'h00);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        check("ovr_clr", overrun, 0);
        eng_valid = 1'b1; eng_data = 8'h99; rd_ready = 1'b1;
        step();
        eng_valid = 1'b0; rd_ready = 1'b0;
        check("ovr_pp_lvl", level, 8);
        check("ovr_pp_flag", overrun, 0);
        for (int i = 1; i <= 8; i++) begin
            check("ovr_drain", rd_data, (i < 8) ? 32'(i) : 32'h99);
            pop1();
        end
        check("ovr_drain_empty", rd_valid, 0);
        check("ovr_drain_lvl", level, 0);

        // wrap
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h10 + i));
            check("wrap_lvl", level, 1);
            check("wrap_data", rd_data, 32'(8'h10 + i));
            pop1();
            check("wrap_lvl0", level, 0);
        end

        // idle timeout
`ifdef UART_RX_TIMEOUT_EN
        push(8'h7E);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (timeout_irq === 1'b1) begin
                n = i;
                break;
            end
        end
        check("to_fire_cycles", n, 161);
        check("to_irq", timeout_irq, 1);
        pop1();
        check("to_pop_empty", rd_valid, 0);
        check("to_pop_irq", timeout_irq, 0);
`else
        push(8'h7E);
        repeat (300) step();
        check("to_disabled_irq", timeout_irq, 0);
        pop1();
        check("to_pop_empty", rd_valid, 0);
`endif
        eng_busy = 1'b1;
        push(8'h7E);
        repeat (300) step();
        check("to_busy_irq", timeout_irq, 0);
        pop1();
        eng_busy = 1'b0;
        check("to_busy_empty", rd_valid, 0);

        // overrun set beats clear, then flush with a same-cycle push
        eng_valid = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            eng_data = 8'(8'h30 + i);
            if (i == 8) clr_overrun = 1'b1;
            step();
        end
        clr_overrun = 1'b0; eng_valid = 1'b0;
        check("ovr_prio", overrun, 1);
        rd_ready = 1'b1; repeat (3) step(); rd_ready = 1'b0;
        check("fl_pre_lvl", level, 5);
        check("fl_pre_head", rd_data, 8'h33);
        cfg_flush = 1'b1; eng_valid = 1'b1; eng_data = 8'hC4; rd_ready = 1'b1;
        step();
        cfg_flush = 1'b0; eng_valid = 1'b0; rd_ready = 1'b0;
        check("fl_lvl", level, 0);
        check("fl_rd_valid", rd_valid, 0);
        check("fl_irq", timeout_irq, 0);
        check("fl_overrun", overrun, 1);
        step();
        check("fl_lvl_hold", level, 0);
        push(8'hAB);
        check("fl_after_data", rd_data, 8'hAB);
        check("fl_after_lvl", level, 1);
        pop1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
